// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_CH runtime-programmable LED channels (off / on / blink / burst)
// clocked from one shared prescaler tick.
module led_pattern_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [3:0]         i_wr_ch,
    input  logic [1:0]         i_wr_mode,
    input  logic [CNT_W-1:0]   i_wr_period,
    input  logic [CNT_W-1:0]   i_wr_on,
    input  logic [BURST_W-1:0] i_wr_burst,
    output logic               o_tick,
    output logic [NUM_CH-1:0]  o_led,
    output logic [NUM_CH-1:0]  o_done
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]    PS_ONE  = PS_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [BURST_W-1:0] BST_ONE = BURST_W'(1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 1");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("led_pattern_gen: NUM_CH must be in 1..16");
        end
    endgenerate

    logic [PS_W-1:0]   r_presc;
    logic              r_tick;
    logic [NUM_CH-1:0] w_led;
    logic [NUM_CH-1:0] w_done;

    // Free-running prescaler; config writes never touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_tick <= (r_presc == PS_LAST);
            if (r_presc == PS_LAST) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PS_ONE;
            end
        end
    end

    assign o_tick = r_tick;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            mode_e              r_mode;
            logic [CNT_W-1:0]   r_period;
            logic [CNT_W-1:0]   r_on;
            logic [CNT_W-1:0]   r_phase;
            logic [BURST_W-1:0] r_burst_left;
            logic               r_done;
            logic               r_led;
            logic               w_wr_hit;
            logic               w_wrap;
            logic               w_running;
            logic               w_led_next;

            // i_wr_ch can only equal c for a real channel, so out-of-range writes hit nothing.
            assign w_wr_hit  = i_wr_en && (i_wr_ch == 4'(c));
            assign w_wrap    = (r_phase == (r_period - CNT_ONE));
            assign w_running = (r_mode == MODE_BLINK) ||
                               ((r_mode == MODE_BURST) && !r_done);

            always_comb begin
                // NOTE: default assignment first so no path can infer a latch.
                w_led_next = 1'b0;
                case (r_mode)
                    MODE_OFF:   w_led_next = 1'b0;
                    MODE_ON:    w_led_next = 1'b1;
                    MODE_BLINK: w_led_next = (r_phase < r_on);
                    MODE_BURST: w_led_next = !r_done && (r_phase < r_on);
                    default:    w_led_next = 1'b0;
                endcase
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mode       <= MODE_OFF;
                    r_period     <= CNT_ONE;
                    r_on         <= '0;
                    r_phase      <= '0;
                    r_burst_left <= '0;
                    r_done       <= 1'b0;
                    r_led        <= 1'b0;
                end else begin
                    r_led <= w_led_next;
                    if (w_wr_hit) begin
                        // A write beats a coincident tick: phase restarts at 0.
                        r_mode       <= mode_e'(i_wr_mode);
                        r_period     <= (i_wr_period == '0) ? CNT_ONE : i_wr_period;
                        r_on         <= i_wr_on;
                        r_phase      <= '0;
                        r_burst_left <= i_wr_burst;
                        r_done       <= 1'b0;
                    end else if ((r_mode == MODE_BURST) && !r_done && (r_burst_left == '0)) begin
                        r_phase <= '0;
                        r_done  <= 1'b1;
                    end else if (r_tick && w_running) begin
                        if (w_wrap) begin
                            r_phase <= '0;
                            if (r_mode == MODE_BURST) begin
                                r_burst_left <= r_burst_left - BST_ONE;
                                if (r_burst_left == BST_ONE) begin
                                    r_done <= 1'b1;
                                end
                            end
                        end else begin
                            r_phase <= r_phase + CNT_ONE;
                        end
                    end
                end
            end

            assign w_led[c]  = r_led;
            assign w_done[c] = r_done;
        end
    endgenerate

    assign o_led  = w_led;
    assign o_done = w_done;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at PRESCALE = 10, four channels; expected
// values are hand-derived edge numbers counted from each reset release.
module tb_led_pattern_gen;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_wr_en = 1'b0;
    logic [3:0]         i_wr_ch = '0;
    logic [1:0]         i_wr_mode = '0;
    logic [CNT_W-1:0]   i_wr_period = '0;
    logic [CNT_W-1:0]   i_wr_on = '0;
    logic [BURST_W-1:0] i_wr_burst = '0;
    logic               o_tick;
    logic [NUM_CH-1:0]  o_led;
    logic [NUM_CH-1:0]  o_done;

    int n_vec = 0;
    int n_err = 0;
    int e     = 0;
    int hi_cnt;
    int rises;
    logic prev;

    always #5 i_clk = ~i_clk;

    led_pattern_gen #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_ch    (i_wr_ch),
        .i_wr_mode  (i_wr_mode),
        .i_wr_period(i_wr_period),
        .i_wr_on    (i_wr_on),
        .i_wr_burst (i_wr_burst),
        .o_tick     (o_tick),
        .o_led      (o_led),
        .o_done     (o_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        e++;
    endtask

    task automatic do_write(input int ch, input int mode, input int period, input int on, input int burst);
        i_wr_en     = 1'b1;
        i_wr_ch     = 4'(ch);
        i_wr_mode   = 2'(mode);
        i_wr_period = CNT_W'(period);
        i_wr_on     = CNT_W'(on);
        i_wr_burst  = BURST_W'(burst);
        step();
        i_wr_en     = 1'b0;
    endtask

    function automatic logic blink0_exp(input int edge_n);
        return ((edge_n - 22) % 40) < 10;
    endfunction

    initial begin
        repeat (5) begin
            @(posedge i_clk);
            #1;
            check("reset_idle", 32'({o_tick, o_done, o_led}), 32'h0);
        end
        i_rst_n = 1'b1;
        e = 0;

        for (int i = 1; i <= 20; i++) begin
            step();
            check("tick", 32'(o_tick), 32'(i % 10 == 0));
            check("idle_out", 32'({o_done, o_led}), 32'h0);
        end

        step();
        do_write(0, 2, 4, 1, 0);
        check("blink_latency", 32'(o_led[0]), 32'h0);
        while (e < 101) begin
            step();
            check("blink_ch0", 32'(o_led[0]), 32'(blink0_exp(e)));
            check("blink_others", 32'(o_led[3:1]), 32'h0);
        end

        do_write(1, 2, 5, 0, 0);
        check("blink_ch0_w1", 32'(o_led[0]), 32'(blink0_exp(e)));
        do_write(2, 2, 5, 7, 0);
        check("blink_ch0_w2", 32'(o_led[0]), 32'(blink0_exp(e)));
        do_write(3, 2, 0, 1, 0);
        check("blink_ch0_w3", 32'(o_led[0]), 32'(blink0_exp(e)));
        while (e < 164) begin
            step();
            check("duty_bounds", 32'(o_led[3:1]), 32'b110);
            check("blink_ch0_indep", 32'(o_led[0]), 32'(blink0_exp(e)));
        end

        while (e < 170) step();
        do_write(0, 3, 2, 1, 3);
        check("burst_pre", 32'(o_led[0]), 32'h0);
        hi_cnt = 0;
        rises  = 0;
        prev   = 1'b0;
        while (e < 250) begin
            step();
            check("burst_led", 32'(o_led[0]),
                  32'((e >= 172 && e <= 181) || (e >= 192 && e <= 201) || (e >= 212 && e <= 221)));
            check("burst_done", 32'(o_done[0]), 32'(e >= 231));
            check("burst_others", 32'(o_led[3:1]), 32'b110);
            if (o_led[0]) hi_cnt++;
            if (o_led[0] && !prev) rises++;
            prev = o_led[0];
        end
        check("burst_pulses", 32'(rises), 32'd3);
        check("burst_high_clks", 32'(hi_cnt), 32'd30);

        do_write(0, 3, 2, 0, 0);
        check("done_clear", 32'(o_done[0]), 32'h0);
        step();
        check("zero_burst_done", 32'(o_done[0]), 32'h1);
        step();
        check("zero_burst_hold", 32'({o_done[0], o_led[0]}), 32'b10);

        do_write(9, 1, 1, 1, 0);
        while (e < 260) begin
            step();
            check("bad_ch_led", 32'(o_led), 32'b1100);
            check("bad_ch_done", 32'(o_done), 32'b0001);
        end

        do_write(1, 2, 3, 2, 0);
        check("collide_pre", 32'(o_led[1]), 32'h0);
        while (e < 311) begin
            step();
            check("collide_ch1", 32'(o_led[1]), 32'(((e - 262) % 30) < 20));
            check("collide_others", 32'({o_led[3:2], o_led[0]}), 32'b110);
        end

        do_write(0, 3, 2, 1, 5);
        step();
        check("reburst_led", 32'(o_led[0]), 32'h1);
        step();
        check("reburst_all", 32'(o_led), 32'b1101);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", 32'({o_tick, o_done, o_led}), 32'h0);
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("reset_hold", 32'({o_tick, o_done, o_led}), 32'h0);
        end
        i_rst_n = 1'b1;
        e = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            check("post_rst_tick", 32'(o_tick), 32'(i % 10 == 0));
            check("post_rst_off", 32'({o_done, o_led}), 32'h0);
        end
        do_write(2, 1, 1, 0, 0);
        check("on_latency", 32'(o_led), 32'h0);
        step();
        check("on_mode", 32'(o_led), 32'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
